// File: rtl/paddle_move_ctl.sv
// paddle_move_ctl
// Button-to-paddle movement controller for the two-player pong datapath.
// Raw buttons are synchronised and debounced, a frame divider sets the
// movement schedule, and a small FSM per player turns held directions into
// one-cycle step strobes. A direction held long enough switches that player
// to two steps per frame.
//
// Ports
//   clk         system clock
//   rstn        asynchronous active-low reset
//   btn_raw     raw buttons, active-high, asynchronous
//               bit0 ply1 up, bit1 ply1 down, bit2 ply2 up, bit3 ply2 down
//   btn_state   debounced button levels, same bit order
//   frame_tick  one-cycle pulse per movement frame
//   ply1_up, ply1_down, ply2_up, ply2_down
//               one-cycle step strobes to the paddle position registers
//
// Player FSM
//   state | meaning
//   IDLE  | no single direction requested, no steps
//   SLOW  | one step per frame, counting frames toward FAST
//   FAST  | two steps per frame (tick+1 and tick+2)

module paddle_move_ctl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FRAME_DIV       = 416667,
  parameter int HOLD_FRAMES     = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_state,
  output logic       frame_tick,
  output logic       ply1_up,
  output logic       ply1_down,
  output logic       ply2_up,
  output logic       ply2_down
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FDW = $clog2(FRAME_DIV);
  localparam int HW  = $clog2(HOLD_FRAMES + 1);

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FDW-1:0] FRAME_LAST = FDW'(FRAME_DIV - 1);
  localparam logic [HW-1:0]  HOLD_LAST  = HW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } mv_state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------
  logic [3:0] sync1;
  logic [3:0] sync2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debouncers: the level only moves after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any agreement restarts the count.
  // ---------------------------------------------------------------------
  for (genvar b = 0; b < 4; b++) begin : g_db
    logic [DBW-1:0] db_cnt;
    logic           db_level;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        db_cnt   <= '0;
        db_level <= 1'b0;
      end else if (sync2[b] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync2[b];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end

    assign btn_state[b] = db_level;
  end

  // ---------------------------------------------------------------------
  // Frame divider; the tick is a flop so the first one lands exactly
  // FRAME_DIV cycles after reset release.
  // ---------------------------------------------------------------------
  logic [FDW-1:0] frame_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_cnt  <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FDW'(1);
      frame_tick <= (frame_cnt == FRAME_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Per-player movement FSM
  // ---------------------------------------------------------------------
  logic [1:0] step_up;
  logic [1:0] step_dn;

  for (genvar p = 0; p < 2; p++) begin : g_ply
    mv_state_t      state_q, state_d;
    logic           dir_q, dir_d;      // 0 = up, 1 = down
    logic [HW-1:0]  hold_q, hold_d;
    logic           pend_q, pend_d;    // second FAST step owed next cycle
    logic           up_q, up_d;
    logic           dn_q, dn_d;
    logic           req;
    logic           req_dir;
    logic           fire;

    assign req     = btn_state[2*p] ^ btn_state[2*p+1];
    assign req_dir = btn_state[2*p+1];

    always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      hold_d  = hold_q;
      pend_d  = 1'b0;
      fire    = 1'b0;

      case (state_q)
        IDLE: begin
          if (req) begin
            state_d = SLOW;
            dir_d   = req_dir;
            hold_d  = '0;
          end
        end
        SLOW, FAST: begin
          // Release, conflict and reversal are checked every cycle and
          // override tick handling; this also drops an owed FAST step.
          if (!req) begin
            state_d = IDLE;
          end else if (req_dir != dir_q) begin
            state_d = SLOW;
            dir_d   = req_dir;
            hold_d  = '0;
          end else begin
            if (pend_q) begin
              fire = 1'b1;
            end
            if (frame_tick) begin
              fire = 1'b1;
              if (state_q == FAST) begin
                pend_d = 1'b1;
              end else if (hold_q == HOLD_LAST) begin
                state_d = FAST;
              end else begin
                hold_d = hold_q + HW'(1);
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      up_d = fire & ~dir_q;
      dn_d = fire &  dir_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= IDLE;
        dir_q   <= 1'b0;
        hold_q  <= '0;
        pend_q  <= 1'b0;
        up_q    <= 1'b0;
        dn_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        dir_q   <= dir_d;
        hold_q  <= hold_d;
        pend_q  <= pend_d;
        up_q    <= up_d;
        dn_q    <= dn_d;
      end
    end

    assign step_up[p] = up_q;
    assign step_dn[p] = dn_q;
  end

  assign ply1_up   = step_up[0];
  assign ply1_down = step_dn[0];
  assign ply2_up   = step_up[1];
  assign ply2_down = step_dn[1];

endmodule

// File: tb/tb_paddle_move_ctl.sv
// Bench for paddle_move_ctl with DEBOUNCE_CYCLES=4, FRAME_DIV=10,
// HOLD_FRAMES=3. Stimulus pushes hand-computed strobe events (cycle number
// and {ply2_down, ply2_up, ply1_down, ply1_up}) into a scoreboard; a monitor
// thread compares them against the strobes the DUT actually produces.
// Cycle numbers count rising edges; everything is sampled on falling edges.

module tb_paddle_move_ctl;

  localparam int DB = 4;
  localparam int FD = 10;
  localparam int HF = 3;

  logic       clk;
  logic       rstn;
  logic [3:0] btn_raw;
  logic [3:0] btn_state;
  logic       frame_tick;
  logic       ply1_up, ply1_down, ply2_up, ply2_down;

  paddle_move_ctl #(
    .DEBOUNCE_CYCLES(DB),
    .FRAME_DIV      (FD),
    .HOLD_FRAMES    (HF)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_raw   (btn_raw),
    .btn_state (btn_state),
    .frame_tick(frame_tick),
    .ply1_up   (ply1_up),
    .ply1_down (ply1_down),
    .ply2_up   (ply2_up),
    .ply2_down (ply2_down)
  );

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   r0  = 0;
  int   errors = 0;
  int   checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic int next_tick(input int c);
    return r0 + FD * ((c - r0) / FD + 1);
  endfunction

  task automatic monitor();
    logic [3:0] sv;
    forever begin
      @(negedge clk);
      sv = {ply2_down, ply2_up, ply1_down, ply1_up};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL strobe_missing: got none at cycle %0d expected %b", sb[0].cyc, sb[0].vec);
        void'(sb.pop_front());
      end
      if (sv != 4'b0000) begin
        checks++;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          errors++;
          $display("FAIL strobe_unexpected: got %b at cycle %0d expected none", sv, cyc);
        end else begin
          if (sb[0].vec !== sv) begin
            errors++;
            $display("FAIL strobe_value: got %b at cycle %0d expected %b", sv, cyc, sb[0].vec);
          end
          void'(sb.pop_front());
        end
      end
    end
  endtask

  int t, t0, t1, t2, t3;

  initial begin
    rstn    = 1'b0;
    btn_raw = 4'hF;
    fork
      monitor();
    join_none

    // Reset with all buttons pressed
    repeat (4) @(negedge clk);
    check("reset_outputs", {btn_state, frame_tick, ply2_down, ply2_up, ply1_down, ply1_up}, 9'h000);
    btn_raw = 4'h0;
    rstn    = 1'b1;
    r0      = cyc;
    for (int k = 1; k <= 25; k++) begin
      wait_cyc(r0 + k);
      check("frame_tick", {8'h00, frame_tick}, {8'h00, (k % FD) == 0});
    end

    // Debounce: 1-cycle and 3-cycle glitches are ignored
    t = next_tick(cyc);
    wait_cyc(t);
    btn_raw = 4'b0001;
    wait_cyc(t + 1);
    btn_raw = 4'b0000;
    for (int k = 2; k <= 9; k++) begin
      wait_cyc(t + k);
      check("glitch1_state", {5'h0, btn_state}, 9'h000);
    end
    wait_cyc(t + 10);
    btn_raw = 4'b0001;
    wait_cyc(t + 13);
    btn_raw = 4'b0000;
    for (int k = 14; k <= 19; k++) begin
      wait_cyc(t + k);
      check("glitch3_state", {5'h0, btn_state}, 9'h000);
    end

    // 8-cycle hold: level rises 6 edges after press, falls 6 after release,
    // and the SLOW window covers one tick.
    t = t + 20;
    wait_cyc(t);
    push(t + 11, 4'b0001);
    btn_raw = 4'b0001;
    wait_cyc(t + 5);
    check("hold8_pre", {5'h0, btn_state}, 9'h000);
    wait_cyc(t + 6);
    check("hold8_rise", {5'h0, btn_state}, 9'h001);
    wait_cyc(t + 8);
    btn_raw = 4'b0000;
    wait_cyc(t + 13);
    check("hold8_high", {5'h0, btn_state}, 9'h001);
    wait_cyc(t + 14);
    check("hold8_fall", {5'h0, btn_state}, 9'h000);

    // Slow to fast on ply1 down; release lands in a tick cycle
    t0 = next_tick(cyc);
    wait_cyc(t0);
    push(t0 + 11, 4'b0010);
    push(t0 + 21, 4'b0010);
    push(t0 + 31, 4'b0010);
    push(t0 + 41, 4'b0010);
    push(t0 + 42, 4'b0010);
    push(t0 + 51, 4'b0010);
    push(t0 + 52, 4'b0010);
    btn_raw = 4'b0010;
    wait_cyc(t0 + 54);
    btn_raw = 4'b0000;
    wait_cyc(t0 + 59);
    check("p1_rel_high", {5'h0, btn_state}, 9'h002);
    wait_cyc(t0 + 60);
    check("p1_rel_tick", {5'h0, btn_state, frame_tick}, 9'h001);

    // ply2 conflict, then up alone restarts at single rate; release lands
    // between T and T+2 in FAST so only the first step of that tick appears.
    t1 = next_tick(t0 + 60);
    wait_cyc(t1);
    push(t1 + 11,  4'b0100);
    push(t1 + 21,  4'b0100);
    push(t1 + 31,  4'b0100);
    push(t1 + 41,  4'b0100);
    push(t1 + 42,  4'b0100);
    push(t1 + 71,  4'b0100);
    push(t1 + 81,  4'b0100);
    push(t1 + 91,  4'b0100);
    push(t1 + 101, 4'b0100);
    push(t1 + 102, 4'b0100);
    push(t1 + 111, 4'b0100);
    btn_raw = 4'b0100;
    wait_cyc(t1 + 40);
    btn_raw = 4'b1100;
    wait_cyc(t1 + 46);
    check("p2_both", {5'h0, btn_state}, 9'h00C);
    wait_cyc(t1 + 60);
    btn_raw = 4'b0100;
    wait_cyc(t1 + 105);
    btn_raw = 4'b0000;
    wait_cyc(t1 + 111);
    check("p2_rel_mid", {5'h0, btn_state}, 9'h000);

    // Independence: ply1 up in FAST while ply2 down is tapped, then ply1
    // reverses to down and drops back to single rate.
    wait_cyc(t1 + 112);
    t2 = next_tick(cyc);
    wait_cyc(t2);
    push(t2 + 11, 4'b0001);
    push(t2 + 21, 4'b0001);
    push(t2 + 31, 4'b0001);
    push(t2 + 41, 4'b0001);
    push(t2 + 42, 4'b0001);
    push(t2 + 51, 4'b1001);
    push(t2 + 52, 4'b0001);
    push(t2 + 61, 4'b0001);
    push(t2 + 62, 4'b0001);
    push(t2 + 71, 4'b0010);
    btn_raw = 4'b0001;
    wait_cyc(t2 + 40);
    btn_raw = 4'b1001;
    wait_cyc(t2 + 46);
    check("ind_tap", {5'h0, btn_state}, 9'h009);
    wait_cyc(t2 + 48);
    btn_raw = 4'b0001;
    wait_cyc(t2 + 60);
    btn_raw = 4'b0010;
    wait_cyc(t2 + 66);
    check("ind_rev", {5'h0, btn_state}, 9'h002);
    wait_cyc(t2 + 70);
    btn_raw = 4'b0000;

    // Async reset between T+1 and T+2 in FAST
    wait_cyc(t2 + 77);
    t3 = next_tick(cyc);
    wait_cyc(t3);
    push(t3 + 11, 4'b0001);
    push(t3 + 21, 4'b0001);
    push(t3 + 31, 4'b0001);
    push(t3 + 41, 4'b0001);
    btn_raw = 4'b0001;
    wait_cyc(t3 + 41);
    #1 rstn = 1'b0;
    #1 check("midreset_outputs", {btn_state, frame_tick, ply2_down, ply2_up, ply1_down, ply1_up}, 9'h000);
    wait_cyc(t3 + 45);
    rstn = 1'b1;
    r0   = cyc;
    push(r0 + 11, 4'b0001);
    wait_cyc(r0 + 5);
    check("rearm_pre", {5'h0, btn_state}, 9'h000);
    wait_cyc(r0 + 6);
    check("rearm_rise", {5'h0, btn_state}, 9'h001);
    wait_cyc(r0 + 10);
    check("rearm_tick", {8'h00, frame_tick}, 9'h001);
    btn_raw = 4'b0000;
    wait_cyc(r0 + 30);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/paddle_move_ctl.md
# paddle_move_ctl

Button-to-paddle movement controller for the two-player pong datapath. Synchronises and debounces the four raw paddle buttons, generates the frame-rate movement schedule, and emits one-cycle step strobes (ply1_up, ply1_down, ply2_up, ply2_down) that drive the paddle position registers. Holding a direction beyond a threshold switches that player to double-rate movement (auto-acceleration).

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before a debounced level changes (10 ms at 25 MHz)
- FRAME_DIV, 416667: clk cycles per movement frame (60 Hz at 25 MHz); must be ≥ 3
- HOLD_FRAMES, 20: frame ticks a direction must be held in SLOW before entering FAST; ≥ 1
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- btn_raw  in  4  raw buttons, active-high, asynchronous; bit0 ply1 up, bit1 ply1 down, bit2 ply2 up, bit3 ply2 down
- btn_state  out  4  debounced button levels, same bit order
- frame_tick  out  1  one-cycle pulse per movement frame
- ply1_up, ply1_down, ply2_up, ply2_down  out  1 each  one-cycle step strobes to the position datapath

## Operation
- Input path per bit: 2-FF synchroniser → debouncer. Debouncer holds a counter (width $clog2(DEBOUNCE_CYCLES+1)); counter clears whenever synchronised input equals btn_state; otherwise increments; when it reaches DEBOUNCE_CYCLES-1 while still differing, btn_state takes the new level next cycle and counter clears. A single-cycle glitch never changes btn_state.
- Frame divider: counter 0..FRAME_DIV-1, wraps to 0; frame_tick = 1 when counter == FRAME_DIV-1 (registered, one cycle wide).
- Per player, independent FSM {IDLE, SLOW, FAST}, direction register dir (UP/DOWN), hold counter (width $clog2(HOLD_FRAMES+1)). "Request" = exactly one of that player's debounced up/down set.
  - IDLE: request → SLOW, dir = requested direction, hold = 0.
  - SLOW/FAST: no request (released or both pressed) → IDLE. Request in opposite direction → SLOW, new dir, hold = 0. Evaluated every cycle, not only on ticks; takes priority over tick handling in the same cycle.
  - SLOW on frame_tick with same request: hold += 1; if hold == HOLD_FRAMES-1 → FAST (hold saturates).
  - FAST: stays FAST while same request holds.
- Strobes: on a frame_tick cycle T where registered state is SLOW or FAST and no exit/reversal occurs in T, the dir strobe is asserted at T+1. If state at T is FAST, the same strobe is also asserted at T+2 (two steps per frame). The SLOW→FAST transitioning tick produces a single strobe.
- Up and down strobes of one player are never asserted in the same cycle. Players never interact.

## Timing
- Reset (rstn low, async): all outputs 0, btn_state = 0, synchronisers 0, debounce/divider/hold counters 0, both FSMs IDLE, dir = UP. Outputs take reset values immediately; release is synchronous to clk.
- btn_raw edge to btn_state change: 2 (sync) + DEBOUNCE_CYCLES cycles, ±1 for input sampling.
- btn_state to FSM: FSM state updates on the cycle after btn_state changes.
- First frame_tick: FRAME_DIV cycles after reset release; then every FRAME_DIV cycles exactly.
- Strobe latency from frame_tick: 1 cycle (SLOW), 1 and 2 cycles (FAST). FRAME_DIV ≥ 3 guarantees the second FAST strobe finishes before the next tick.
- Release/reversal in the cycle of frame_tick: no strobe for that tick. Release between T and T+2 in FAST: the already-scheduled T+2 strobe is suppressed.
- Reset mid-frame clears pending strobes; no strobe appears after rstn falls.

## Test plan
Parameters for bench: DEBOUNCE_CYCLES=4, FRAME_DIV=10, HOLD_FRAMES=3.
- Reset: hold rstn low with btn_raw=4'hF → all outputs 0; release → first frame_tick exactly 10 cycles later, then every 10 cycles.
- Debounce: 1-cycle and 3-cycle pulses on btn_raw[0] → btn_state stays 0, no strobes; 8-cycle hold → btn_state[0]=1 about 6 cycles after edge.
- Slow→fast: hold btn_raw[1] → ply1_down single strobe 1 cycle after each of ticks 1–3 following btn_state rise, then two strobes (T+1, T+2) per tick; ply1_up never asserted.
- Conflict/reversal: in FAST press ply2_up and ply2_down together → no ply2 strobes; release down → ply2_up strobes restart single-rate for 3 ticks.
- Independence: ply1 up held in FAST while ply2 down tapped → ply1 pattern unchanged, ply2 single strobes only.
- Async reset mid-FAST between T and T+2 → T+2 strobe absent, FSMs IDLE, btn_state 0 after release until re-debounced.
